// File: rtl/dna_pkg.sv
// Shared definitions for the DNA_PORT emulator.
//   DNA_W       : width of the device identifier (57 bits)
//   BITCNT_W    : width of the shift counter (saturates at all-ones)
//   DNA_DEFAULT : identifier loaded on READ unless overridden
//   dna_state_e : responder state (IDLE, LOADED, SHIFTING, EXHAUSTED)
//   sat_inc     : saturating increment for the shift counter
package dna_pkg;

  localparam int DNA_W    = 57;
  localparam int BITCNT_W = 7;

  localparam logic [DNA_W-1:0] DNA_DEFAULT = 57'h1_2345_6789_ABCD_EF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOADED    = 2'd1,
    SHIFTING  = 2'd2,
    EXHAUSTED = 2'd3
  } dna_state_e;

  function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
    return (v == '1) ? v : v + BITCNT_W'(1);
  endfunction

endpackage

// File: rtl/dna_in_sync.sv
// Multi-bit input synchroniser with edge pulses on a strobe bit.
// The strobe and the data travel through the same flop chain as one vector,
// so the data seen alongside a strobe edge is exactly what was at the pins
// when that edge was captured.
// Ports:
//   clk, srst    : clock and synchronous active-high reset
//   strobe       : asynchronous strobe (the reader's dna_clk)
//   data         : asynchronous qualifier bits travelling with the strobe
//   data_sync    : synchronised data, aligned with the edge pulses
//   strobe_rise  : one-cycle pulse, synchronised strobe went 0 -> 1
//   strobe_fall  : one-cycle pulse, synchronised strobe went 1 -> 0
module dna_in_sync #(
  parameter int W      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         strobe,
  input  logic [W-1:0] data,
  output logic [W-1:0] data_sync,
  output logic         strobe_rise,
  output logic         strobe_fall
);

  // Bit 0 of every stage is the strobe, the upper bits are the data.
  logic [W:0] stage_reg [STAGES];
  logic       strobe_prev_reg;
  logic [W:0] last_stage;

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
      strobe_prev_reg <= 1'b0;
    end else begin
      stage_reg[0] <= {data, strobe};
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      strobe_prev_reg <= stage_reg[STAGES-1][0];
    end
  end

  assign last_stage  = stage_reg[STAGES-1];
  assign data_sync   = last_stage[W:1];
  assign strobe_rise =  last_stage[0] & ~strobe_prev_reg;
  assign strobe_fall = ~last_stage[0] &  strobe_prev_reg;

endmodule

// File: rtl/dna_port_emu.sv
// Synthesizable stand-in for the device DNA_PORT primitive (responder side).
// The reader's dna_clk/read/shift/din are sampled on sys_clk; on each
// synchronised dna_clk rise the 57-bit shift register is loaded or shifted
// and its MSB is presented on dna_dout. Protocol and timing violations are
// latched in sticky flags that only sys_rst clears.
// Ports:
//   sys_clk, sys_rst : system clock, synchronous active-high reset
//   dna_clk          : reader shift clock (asynchronous, slower than sys_clk)
//   dna_read         : load DNA_VALUE on dna_clk rise
//   dna_shift        : shift one bit on dna_clk rise
//   dna_din          : serial input shifted into the LSB
//   dna_dout         : shift register bit 56
//   bit_cnt          : shifts since last READ, saturating at 127
//   dna_loaded       : a READ has occurred since reset
//   proto_err        : sticky, READ and SHIFT were high at the same edge
//   timing_err       : sticky, a dna_clk phase was shorter than MIN_HALF
module dna_port_emu
  import dna_pkg::*;
#(
  parameter logic [DNA_W-1:0] DNA_VALUE   = DNA_DEFAULT,
  parameter int               SYNC_STAGES = 2,
  parameter int               MIN_HALF    = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                dna_clk,
  input  logic                dna_read,
  input  logic                dna_shift,
  input  logic                dna_din,
  output logic                dna_dout,
  output logic [BITCNT_W-1:0] bit_cnt,
  output logic                dna_loaded,
  output logic                proto_err,
  output logic                timing_err
);

  // Phase counter only needs to reach MIN_HALF; one extra bit of headroom
  // keeps the saturation point clear of the threshold.
  localparam int                PH_W       = $clog2(MIN_HALF + 1) + 1;
  localparam logic [PH_W-1:0]   PH_MAX     = '1;
  localparam logic [PH_W-1:0]   MIN_HALF_C = PH_W'(MIN_HALF);
  localparam logic [BITCNT_W-1:0] EXHAUST_AT = BITCNT_W'(DNA_W);

  // Synchronised reader inputs
  logic [2:0] data_sync;
  logic       clk_rise;
  logic       clk_fall;

  dna_in_sync #(
    .W      (3),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk         (sys_clk),
    .srst        (sys_rst),
    .strobe      (dna_clk),
    .data        ({dna_read, dna_shift, dna_din}),
    .data_sync   (data_sync),
    .strobe_rise (clk_rise),
    .strobe_fall (clk_fall)
  );

  // Registered edge event; the action happens one cycle after detection so
  // the shift register sees a clean, flop-sourced command.
  logic ev_rise_reg;
  logic ev_read_reg;
  logic ev_shift_reg;
  logic ev_din_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ev_rise_reg  <= 1'b0;
      ev_read_reg  <= 1'b0;
      ev_shift_reg <= 1'b0;
      ev_din_reg   <= 1'b0;
    end else begin
      ev_rise_reg  <= clk_rise;
      ev_read_reg  <= data_sync[2];
      ev_shift_reg <= data_sync[1];
      ev_din_reg   <= data_sync[0];
    end
  end

  // Shift register, counter and state
  logic [DNA_W-1:0]    sreg_reg,      sreg_next;
  logic [BITCNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
  logic                proto_err_reg, proto_err_next;
  dna_state_e          state_reg,     state_next;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sreg_reg      <= '0;
      bit_cnt_reg   <= '0;
      proto_err_reg <= 1'b0;
      state_reg     <= IDLE;
    end else begin
      sreg_reg      <= sreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      proto_err_reg <= proto_err_next;
      state_reg     <= state_next;
    end
  end

  always_comb begin
    sreg_next      = sreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    proto_err_next = proto_err_reg;
    state_next     = state_reg;
    if (ev_rise_reg) begin
      if (ev_read_reg) begin
        // READ has priority; a simultaneous SHIFT is ignored but flagged.
        sreg_next    = DNA_VALUE;
        bit_cnt_next = '0;
        state_next   = LOADED;
        if (ev_shift_reg) begin
          proto_err_next = 1'b1;
        end
      end else if (ev_shift_reg) begin
        sreg_next    = {sreg_reg[DNA_W-2:0], ev_din_reg};
        bit_cnt_next = sat_inc(bit_cnt_reg);
        // Shifting before any READ still moves data but stays in IDLE.
        if (state_reg != IDLE) begin
          state_next = (bit_cnt_next >= EXHAUST_AT) ? EXHAUSTED : SHIFTING;
        end
      end
    end
  end

  // dna_clk phase-width check
  logic [PH_W-1:0] phase_cnt_reg;
  logic            seen_edge_reg;
  logic            timing_err_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_cnt_reg  <= '0;
      seen_edge_reg  <= 1'b0;
      timing_err_reg <= 1'b0;
    end else if (clk_rise || clk_fall) begin
      // The first transition after reset has no preceding phase to measure.
      if (seen_edge_reg && (phase_cnt_reg < MIN_HALF_C)) begin
        timing_err_reg <= 1'b1;
      end
      seen_edge_reg <= 1'b1;
      phase_cnt_reg <= PH_W'(1);
    end else if (phase_cnt_reg != PH_MAX) begin
      phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
    end
  end

  assign dna_dout   = sreg_reg[DNA_W-1];
  assign bit_cnt    = bit_cnt_reg;
  assign dna_loaded = (state_reg != IDLE);
  assign proto_err  = proto_err_reg;
  assign timing_err = timing_err_reg;

endmodule
